// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe
// Purpose  : Pipelined main control for a 5-stage MIPS core. Decodes the ID
//            opcode, carries EX/M/WB control through ID/EX, EX/MEM, MEM/WB,
//            and handles load-use stalls, branch flushes and illegal opcodes.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
    parameter int OPCODE_WIDTH   = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int BR_STAGE       = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [OPCODE_WIDTH-1:0]   id_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      br_taken,
    output logic                      stall,
    output logic                      flush_ifid,
    output logic                      ex_valid,
    output logic                      ex_reg_dst,
    output logic                      ex_alu_src,
    output logic [1:0]                ex_alu_op,
    output logic [REG_ADDR_WIDTH-1:0] ex_rt,
    output logic                      mem_valid,
    output logic                      mem_branch,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic                      wb_valid,
    output logic                      wb_reg_src,
    output logic                      wb_reg_write,
    output logic                      illegal_op,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    localparam logic [OPCODE_WIDTH-1:0] c_OP_RTYPE = OPCODE_WIDTH'('h00);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_LW    = OPCODE_WIDTH'('h23);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_SW    = OPCODE_WIDTH'('h2B);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_BEQ   = OPCODE_WIDTH'('h04);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_ADDI  = OPCODE_WIDTH'('h08);

    typedef struct packed {
        logic       valid;
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_src;
        logic       reg_write;
    } ex_ctrl_t;

    typedef struct packed {
        logic valid;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic reg_src;
        logic reg_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic valid;
        logic reg_src;
        logic reg_write;
    } wb_ctrl_t;

    ex_ctrl_t                  ex_q,  ex_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rt_q, ex_rt_d;
    mem_ctrl_t                 mem_q, mem_d;
    wb_ctrl_t                  wb_q,  wb_d;
    logic                      illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]      flush_cnt_q, flush_cnt_d;

    ex_ctrl_t w_dec;
    logic     w_legal;
    logic     w_uses_rt;
    logic     w_load_use;
    logic     w_stall;

    always_comb begin
        w_dec     = '0;
        w_legal   = 1'b1;
        w_uses_rt = 1'b0;
        case (id_opcode)
            c_OP_RTYPE: begin
                w_dec.reg_dst   = 1'b1;
                w_dec.alu_op    = 2'b10;
                w_dec.reg_write = 1'b1;
                w_uses_rt       = 1'b1;
            end
            c_OP_LW: begin
                w_dec.alu_src   = 1'b1;
                w_dec.mem_read  = 1'b1;
                w_dec.reg_src   = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            c_OP_SW: begin
                w_dec.alu_src   = 1'b1;
                w_dec.mem_write = 1'b1;
                w_uses_rt       = 1'b1;
            end
            c_OP_BEQ: begin
                w_dec.alu_op    = 2'b01;
                w_dec.branch    = 1'b1;
                w_uses_rt       = 1'b1;
            end
            c_OP_ADDI: begin
                w_dec.alu_src   = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
        w_dec.valid = 1'b1;
    end

    // rt is only a true source for RTYPE, SW and BEQ; for LW/ADDI it is the destination.
    always_comb begin
        w_load_use = ex_q.valid && ex_q.mem_read && id_valid &&
                     (ex_rt_q != '0) &&
                     ((ex_rt_q == id_rs) || ((ex_rt_q == id_rt) && w_uses_rt));
        w_stall    = w_load_use && !br_taken;
    end

    always_comb begin
        ex_d    = '0;
        ex_rt_d = '0;
        if (id_valid && w_legal && !w_load_use && !br_taken) begin
            ex_d    = w_dec;
            ex_rt_d = id_rt;
        end
    end

    generate
        if (BR_STAGE == 2) begin : g_br_mem
            // Branch resolves in MEM, so the younger instruction in EX is wrong-path too.
            always_comb begin
                mem_d = '0;
                if (!br_taken) begin
                    mem_d = '{valid: ex_q.valid, branch: ex_q.branch,
                              mem_read: ex_q.mem_read, mem_write: ex_q.mem_write,
                              reg_src: ex_q.reg_src, reg_write: ex_q.reg_write};
                end
            end
        end else begin : g_br_ex
            always_comb begin
                mem_d = '{valid: ex_q.valid, branch: ex_q.branch,
                          mem_read: ex_q.mem_read, mem_write: ex_q.mem_write,
                          reg_src: ex_q.reg_src, reg_write: ex_q.reg_write};
            end
        end
    endgenerate

    always_comb begin
        wb_d        = '{valid: mem_q.valid, reg_src: mem_q.reg_src,
                        reg_write: mem_q.reg_write};
        illegal_d   = illegal_q || (id_valid && !w_legal);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (w_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (br_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= '0;
            ex_rt_q     <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            ex_rt_q     <= ex_rt_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall        = w_stall;
    assign flush_ifid   = br_taken;
    assign ex_valid     = ex_q.valid;
    assign ex_reg_dst   = ex_q.reg_dst;
    assign ex_alu_src   = ex_q.alu_src;
    assign ex_alu_op    = ex_q.alu_op;
    assign ex_rt        = ex_rt_q;
    assign mem_valid    = mem_q.valid;
    assign mem_branch   = mem_q.branch;
    assign mem_read     = mem_q.mem_read;
    assign mem_write    = mem_q.mem_write;
    assign wb_valid     = wb_q.valid;
    assign wb_reg_src   = wb_q.reg_src;
    assign wb_reg_write = wb_q.reg_write;
    assign illegal_op   = illegal_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule
`default_nettype wire
